// File: rtl/lzc_seq_pkg.sv
// Shared types for the iterative leading-zero counter: count modes, FSM states
// and a helper that sizes the chunk index register.
package lzc_seq_pkg;

   typedef enum logic [1:0] {
      LZC_CLZ = 2'b00,
      LZC_CLO = 2'b01,
      LZC_CTZ = 2'b10,
      LZC_CTO = 2'b11
   } lzc_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } lzc_state_t;

   // A single-chunk operand still needs a 1-bit index register.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/lzc_seq_chunk.sv
// Combinational CHUNK-bit leading-zero priority encoder; cnt_o equals CHUNK
// when the slice is all zero, in which case nonzero_o is low.
module lzc_seq_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0]          chunk_i,
   output logic [$clog2(CHUNK+1)-1:0] cnt_o,
   output logic                      nonzero_o
);

   localparam int CCW = $clog2(CHUNK + 1);

   logic [CCW-1:0] cnt_s;

   // Walk upwards so the most-significant set bit is the last one to write.
   always_comb begin
      cnt_s = CCW'(CHUNK);
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk_i[i]) begin
            cnt_s = CCW'(CHUNK - 1 - i);
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

   assign cnt_o     = cnt_s;
   assign nonzero_o = |chunk_i;

endmodule

// File: rtl/lzc_seq.sv
// Iterative handshaked CLZ/CLO/CTZ/CTO unit scanning CHUNK bits per cycle.
// Define LZC_SEQ_FIXED_LATENCY_EN for constant-time (always NCHUNK cycle) scans.
module lzc_seq
   import lzc_seq_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Flush,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [WIDTH-1:0]           Num,
   input  logic [1:0]                 Mode,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [$clog2(WIDTH+1)-1:0] ZeroCnt,
   output logic                       AllZero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(WIDTH + 1);
   localparam int CCW    = $clog2(CHUNK + 1);
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
      $error("lzc_seq: WIDTH must be a nonzero multiple of CHUNK");
   end

   lzc_state_t       state_q, state_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             az_q, az_d;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
   logic             found_q, found_d;
`endif

   logic [WIDTH-1:0] rev_s, op_in_s, shifted_s;
   logic [CHUNK-1:0] chunk_s;
   logic [CCW-1:0]   chunk_cnt_s;
   logic             chunk_nz_s, last_s, accept_s;
   logic [CW-1:0]    chunk_add_s;

   // Every mode is reduced to a CLZ on the captured operand.
   always_comb begin
      rev_s = {<<{Num}};
      case (lzc_mode_t'(Mode))
         LZC_CLZ: op_in_s = Num;
         LZC_CLO: op_in_s = ~Num;
         LZC_CTZ: op_in_s = rev_s;
         LZC_CTO: op_in_s = ~rev_s;
         default: op_in_s = Num;
      endcase
   end

   assign shifted_s   = op_q << (int'(idx_q) * CHUNK);
   assign chunk_s     = shifted_s[WIDTH-1 -: CHUNK];
   assign last_s      = (idx_q == LAST_IDX);
   assign chunk_add_s = cnt_q + CW'(chunk_cnt_s);
   assign accept_s    = InValid & InReady;

   lzc_seq_chunk #(.CHUNK(CHUNK)) u_chunk (
      .chunk_i   (chunk_s),
      .cnt_o     (chunk_cnt_s),
      .nonzero_o (chunk_nz_s)
   );

   // State and datapath register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= {WIDTH{1'b0}};
         idx_q   <= {IW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         az_q    <= 1'b0;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
         found_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         az_q    <= az_d;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
         found_q <= found_d;
`endif
      end
   end

   // Next-state and datapath update; Flush overrides everything.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      az_d    = az_q;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
      found_d = found_q;
`endif
      if (Flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            SCAN: begin
`ifdef LZC_SEQ_FIXED_LATENCY_EN
               if (!found_q) begin
                  if (chunk_nz_s) begin
                     cnt_d   = chunk_add_s;
                     az_d    = 1'b0;
                     found_d = 1'b1;
                  end else if (last_s) begin
                     cnt_d = CW'(WIDTH);
                     az_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(CHUNK);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
               if (last_s) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = SCAN;
               end
`else
               if (chunk_nz_s) begin
                  cnt_d   = chunk_add_s;
                  az_d    = 1'b0;
                  state_d = DONE;
               end else if (last_s) begin
                  cnt_d   = CW'(WIDTH);
                  az_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + CW'(CHUNK);
                  idx_d   = idx_q + IW'(1);
                  state_d = SCAN;
               end
`endif
            end
            DONE: state_d = OutReady ? IDLE : DONE;
            default: state_d = IDLE;
         endcase
         // Accept from IDLE or back-to-back from DONE.
         if (accept_s) begin
            op_d    = op_in_s;
            idx_d   = {IW{1'b0}};
            cnt_d   = {CW{1'b0}};
            az_d    = 1'b0;
`ifdef LZC_SEQ_FIXED_LATENCY_EN
            found_d = 1'b0;
`endif
            state_d = SCAN;
         end else begin
            op_d = op_q;
         end
      end
   end

   // Handshake outputs decoded from the registered state.
   always_comb begin
      case (state_q)
         IDLE:    InReady = ~Flush;
         DONE:    InReady = OutReady & ~Flush;
         default: InReady = 1'b0;
      endcase
   end

   assign OutValid = (state_q == DONE);
   assign ZeroCnt  = cnt_q;
   assign AllZero  = az_q;

endmodule

// File: tb/tb_lzc_seq.sv
// Scoreboard bench for lzc_seq: the driver pushes expected count/latency on each
// accept, an independent monitor pops and compares on each output handshake.
module tb_lzc_seq;

   localparam int W  = 64;
   localparam int C  = 8;
   localparam int NC = W / C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Flush = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [63:0] Num = 64'd0;
   logic [1:0]  Mode = 2'd0;
   logic        OutValid;
   logic        OutReady = 1'b1;
   logic [6:0]  ZeroCnt;
   logic        AllZero;

   lzc_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .Num(Num), .Mode(Mode), .OutValid(OutValid), .OutReady(OutReady),
      .ZeroCnt(ZeroCnt), .AllZero(AllZero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cnt;
      bit az;
      int lat;
      int acc;
   } exp_t;

   exp_t q[$];
   bit   seen = 1'b0;
   int   seen_cnt;
   bit   seen_az;
   bit   rand_ready = 1'b0;
   bit   ready_fixed = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: count matching bits from the chosen end until the first mismatch.
   function automatic int ref_cnt(input logic [63:0] n, input logic [1:0] m);
      int  c = 0;
      bit  stop = 0;
      logic b;
      for (int i = 0; i < W; i++) begin
         b = m[1] ? n[i] : n[W-1-i];
         if (!stop && b == m[0]) c++;
         else stop = 1;
      end
      return c;
   endfunction

   function automatic int ref_lat(input int c);
`ifdef LZC_SEQ_FIXED_LATENCY_EN
      return NC;
`else
      return (c >= W) ? NC : (c / C) + 1;
`endif
   endfunction

   task automatic push(input int c);
      exp_t e;
      e.cnt = c;
      e.az  = (c == W);
      e.lat = ref_lat(c);
      e.acc = cyc + 1;
      q.push_back(e);
   endtask

   task automatic send(input logic [63:0] n, input logic [1:0] m, input int c);
      int  budget = 300;
      bit  done = 0;
      while (!done) begin
         @(negedge clk);
         Num = n; Mode = m; InValid = 1'b1;
         #1;
         if (InReady) begin
            push(c);
            done = 1;
         end else if (--budget == 0) begin
            chk("send_accept", InReady, 1);
            done = 1;
         end
      end
      @(posedge clk);
      #1;
      InValid = 1'b0;
      Num = {$urandom, $urandom};
      Mode = 2'($urandom_range(0, 3));
   endtask

   task automatic drain(input string name);
      int b = 0;
      while (q.size() != 0 && b < 300) begin
         @(negedge clk);
         b++;
      end
      chk({name, "_drain"}, q.size(), 0);
   endtask

   // Result-side ready driver.
   initial forever begin
      @(negedge clk);
      OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
   end

   // Monitor: latency on first sight, stability under stall, value on handshake.
   initial forever begin
      @(negedge clk);
      #2;
      if (!reset && OutValid) begin
         chk("valid_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            if (!seen) begin
               chk("latency", cyc - q[0].acc, q[0].lat);
               seen = 1'b1;
               seen_cnt = ZeroCnt;
               seen_az = AllZero;
            end else begin
               chk("hold_cnt", ZeroCnt, seen_cnt);
               chk("hold_az", AllZero, seen_az);
            end
            if (OutReady) begin
               chk("zerocnt", ZeroCnt, q[0].cnt);
               chk("allzero", AllZero, q[0].az);
               void'(q.pop_front());
               seen = 1'b0;
            end else if (!Flush) begin
               chk("inready_stall", InReady, 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   logic [63:0] dn [6];
   logic [1:0]  dm [6];
   int          dc [6];

   initial begin
      logic [63:0] v;
      logic [1:0]  m;
      int          b;

      dn[0] = 64'h0080_0000_0000_0000; dm[0] = 2'b00; dc[0] = 8;
      dn[1] = 64'h0000_0000_0000_0000; dm[1] = 2'b00; dc[1] = 64;
      dn[2] = 64'h8000_0000_0000_0000; dm[2] = 2'b00; dc[2] = 0;
      dn[3] = 64'hFFFF_FFFF_FFFF_FFF0; dm[3] = 2'b01; dc[3] = 60;
      dn[4] = 64'h0000_0000_0000_0100; dm[4] = 2'b10; dc[4] = 8;
      dn[5] = 64'h0000_0000_0000_0007; dm[5] = 2'b11; dc[5] = 3;

      #12;
      chk("rst_outvalid", OutValid, 0);
      chk("rst_zerocnt", ZeroCnt, 0);
      chk("rst_allzero", AllZero, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_inready", InReady, 1);

      for (int i = 0; i < 6; i++) begin
         send(dn[i], dm[i], dc[i]);
         drain("directed");
      end

      // Backpressure then back-to-back accept.
      ready_fixed = 1'b0;
      send(64'd0, 2'b00, 64);
      b = 0;
      while (!OutValid && b < 40) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("bp_valid_seen", OutValid, 1);
      repeat (5) @(negedge clk);
      #1;
      chk("bp_inready", InReady, 0);
      chk("bp_valid", OutValid, 1);
      ready_fixed = 1'b1;
      @(negedge clk);
      OutReady = 1'b1; Num = 64'd1; Mode = 2'b00; InValid = 1'b1;
      #1;
      chk("b2b_inready", InReady, 1);
      push(63);
      @(posedge clk);
      #1;
      InValid = 1'b0;
      drain("b2b");

      // Flush during an all-zero scan with an operand offered.
      send(64'd0, 2'b00, 64);
      @(negedge clk);
      @(negedge clk);
      Flush = 1'b1; InValid = 1'b1; Num = 64'hFFFF_FFFF_FFFF_FFFF; Mode = 2'b00;
      #1;
      chk("flush_inready", InReady, 0);
      @(posedge clk);
      #1;
      Flush = 1'b0; InValid = 1'b0;
      q.delete();
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("flush_no_valid", OutValid, 0);
      end
      chk("flush_idle_ready", InReady, 1);
      send(64'h0000_0000_00F0_0000, 2'b00, 40);
      drain("post_flush");

      // Asynchronous reset between edges in the middle of a scan.
      send(64'd0, 2'b00, 64);
      repeat (3) @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("amid_outvalid", OutValid, 0);
      chk("amid_zerocnt", ZeroCnt, 0);
      chk("amid_allzero", AllZero, 0);
      q.delete();
      seen = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("amid_inready", InReady, 1);

      // Randomised traffic with random result backpressure.
      rand_ready = 1'b1;
      for (int t = 0; t < 120; t++) begin
         m = 2'($urandom_range(0, 3));
         b = $urandom_range(0, 9);
         if (b == 0) v = 64'd0;
         else if (b == 1) v = 64'hFFFF_FFFF_FFFF_FFFF;
         else begin
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (m[0]) v = ~v;
            if (m[1]) v = {<<{v}};
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(v, m, ref_cnt(v, m));
      end
      rand_ready = 1'b0;
      ready_fixed = 1'b1;
      drain("random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
